// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: value/dp/control toward the driver,
// segment, anode and frame strobe back from it.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                blank_lz;
  logic                load;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                dp;
  logic                frame_done;

  modport master (
    output value, dp_in, blank_lz, load,
    input  seg, an, dp, frame_done
  );

  modport slave (
    input  value, dp_in, blank_lz, load,
    output seg, an, dp, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with a per-slot guard blank,
// leading-zero blanking and a frame-aligned double buffer.
module seg_scan_driver #(
  parameter int DIGITS        = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int GUARD         = 16,
  parameter int ACTIVE_LOW_AN = 1
) (
  input logic              clock,
  input logic              reset,
  seg_scan_driver_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0]     LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [CW-1:0]     LAST_CNT  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     GUARD_CNT = CW'(GUARD);
  localparam logic [DIGITS-1:0] AN_OFF    = (ACTIVE_LOW_AN != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  pend_q, pend_d, disp_q, disp_d;
  logic [DIGITS-1:0]       pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    frame_end;

  logic [6:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    fd_q;

  logic [DIGITS-1:0]       upper_zero;
  logic [DIGITS-1:0]       en;
  logic                    blanked;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // State register: scan position, both buffers and the registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= '0;
      disp_q    <= '0;
      pend_dp_q <= '0;
      disp_dp_q <= '0;
      seg_q     <= 7'h7F;
      an_q      <= AN_OFF;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      disp_q    <= disp_d;
      pend_dp_q <= pend_dp_d;
      disp_dp_q <= disp_dp_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      fd_q      <= frame_end;
    end
  end

  assign frame_end = (cnt_q == LAST_CNT) && (idx_q == LAST_IDX);

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    // Display takes the pending copy as it stood before any same-edge load.
    if (frame_end) begin
      disp_d    = pend_q;
      disp_dp_d = pend_dp_q;
    end
    if (bus.load) begin
      pend_d    = bus.value;
      pend_dp_d = bus.dp_in;
    end
  end

  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (disp_q[DIGITS-1] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--)
      upper_zero[i] = upper_zero[i+1] && (disp_q[i] == 4'h0);
    blanked = bus.blank_lz && (idx_q != '0) && upper_zero[idx_q];

    en = '0;
    en[idx_q] = 1'b1;

    seg_d = 7'h7F;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if (cnt_q >= GUARD_CNT) begin
      // Blanked digits keep their anode so the decimal point can still show.
      seg_d = blanked ? 7'h7F : hex_to_seg(disp_q[idx_q]);
      an_d  = (ACTIVE_LOW_AN != 0) ? ~en : en;
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle-count reference model queues the
// expected outputs per edge and a negedge monitor compares them.
module tb_seg_scan_driver;
  localparam int D = 4;
  localparam int S = 4;
  localparam int G = 1;
  localparam int FRAME = D * S;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [15:0] drv_value = '0;
  logic [3:0]  drv_dp = '0;
  logic        drv_blank = 1'b0;
  logic        drv_load = 1'b0;

  seg_scan_driver_if #(.DIGITS(D)) bus ();

  assign bus.value    = drv_value;
  assign bus.dp_in    = drv_dp;
  assign bus.blank_lz = drv_blank;
  assign bus.load     = drv_load;

  seg_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .GUARD(G), .ACTIVE_LOW_AN(1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       fd;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  logic [6:0] seg_tab [16];
  initial seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: t counts edges since reset release; slot and phase follow by division.
  int          t = 0;
  logic [15:0] pend_v = '0, disp_v = '0;
  logic [3:0]  pend_dp = '0, disp_dp = '0;

  always @(posedge clock) begin
    exp_t e;
    int slot, ph;
    cyc_n++;
    e.cyc = cyc_n;
    if (reset) begin
      t = 0; pend_v = '0; disp_v = '0; pend_dp = '0; disp_dp = '0;
      e.seg = 7'h7F; e.an = 4'hF; e.dp = 1'b1; e.fd = 1'b0;
    end else begin
      slot = (t / S) % D;
      ph   = t % S;
      e.fd = ((t % FRAME) == FRAME - 1);
      if (ph < G) begin
        e.seg = 7'h7F; e.an = 4'hF; e.dp = 1'b1;
      end else begin
        e.an = 4'hF;
        e.an[slot] = 1'b0;
        if (drv_blank && slot > 0 && (disp_v >> (4 * slot)) == 16'h0)
          e.seg = 7'h7F;
        else
          e.seg = seg_tab[(disp_v >> (4 * slot)) & 16'hF];
        e.dp = ~disp_dp[slot];
      end
      if (e.fd) begin
        disp_v  = pend_v;
        disp_dp = pend_dp;
      end
      if (drv_load) begin
        pend_v  = drv_value;
        pend_dp = drv_dp;
      end
      t++;
    end
    q.push_back(e);
  end

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (bus.seg !== e.seg || bus.an !== e.an || bus.dp !== e.dp || bus.frame_done !== e.fd) begin
        bad++;
        $display("FAIL scan cyc=%0d got seg=%h an=%h dp=%b fd=%b want seg=%h an=%h dp=%b fd=%b",
                 e.cyc, bus.seg, bus.an, bus.dp, bus.frame_done, e.seg, e.an, e.dp, e.fd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    tick(1);
    drv_value = v;
    drv_dp    = d;
    drv_load  = 1'b1;
    tick(1);
    drv_load  = 1'b0;
  endtask

  initial begin
    int fd_cnt, last, gap_bad;
    tick(3);
    @(negedge clock); #2 reset = 1'b0;

    // Eleven edges after release the scanner sits at digit 2, last cycle of its slot.
    do_load(16'h9876, 4'b1010);
    repeat (9) @(posedge clock);
    @(negedge clock); #2 reset = 1'b1;
    #1;
    chk("rst_seg", {25'h0, bus.seg}, 32'h7F);
    chk("rst_an", {28'h0, bus.an}, 32'hF);
    chk("rst_dp", {31'h0, bus.dp}, 32'h1);
    chk("rst_fd", {31'h0, bus.frame_done}, 32'h0);
    tick(2);
    @(negedge clock); #2 reset = 1'b0;

    do_load(16'h12AF, 4'b0000);
    tick(2 * FRAME);

    do_load(16'h1111, 4'b0000);
    tick(3);
    do_load(16'h2222, 4'b0000);
    tick(2 * FRAME + 5);

    drv_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    tick(2 * FRAME + 3);
    do_load(16'h0000, 4'b0000);
    tick(2 * FRAME + 3);
    do_load(16'h0000, 4'b0100);
    tick(2 * FRAME + 3);

    fd_cnt = 0; last = -1; gap_bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        if (last >= 0 && c - last != FRAME) gap_bad++;
        last = c;
      end
    end
    chk("fd_count", fd_cnt, 4);
    chk("fd_spacing", gap_bad, 0);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      drv_load  = ($urandom_range(0, 7) == 0);
      drv_value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      drv_dp    = 4'($urandom);
      if ($urandom_range(0, 31) == 0) drv_blank = ~drv_blank;
    end
    drv_load = 1'b0;
    tick(2 * FRAME);
    @(negedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the hex counter and decoder path.
- Takes a DIGITS-wide packed hex value and drives a multiplexed common-anode seven-segment bank, one digit per scan slot.
- Includes an internal scan prescaler, decodes hex to segments, and blanks a guard interval at each slot start to suppress ghosting.
- Double-buffers the displayed value so it changes only at frame boundaries, which prevents tearing.

Parameters:
- DIGITS, 4: number of digits scanned; index width is clog2(DIGITS), minimum 1.
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least 2.
- GUARD, 16: cycles at the start of each slot with all anodes off; must satisfy 1 <= GUARD < SCAN_DIV.
- ACTIVE_LOW_AN, 1: 1 means an[i]=0 enables digit i; 0 inverts the an polarity.

Ports:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- value, input, 4*DIGITS: packed nibbles; value[3:0] is digit 0, the rightmost and least significant.
- dp_in, input, DIGITS: per-digit decimal point request, 1 = lit.
- blank_lz, input, 1: enables leading-zero blanking; sampled continuously.
- load, input, 1: captures value and dp_in into the pending register.
- seg, output, 7: segment drive {g,f,e,d,c,b,a}, active-low.
- an, output, DIGITS: digit enables, polarity set by ACTIVE_LOW_AN.
- dp, output, 1: decimal point, active-low.
- frame_done, output, 1: one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (async, any time including mid-slot):
  - cnt=0, idx=0, pending=0, disp=0, pending dp=0, disp dp=0.
  - seg=7'h7F, dp=1, an=all-off, frame_done=0.
  - First slot after release is digit 0.
- Prescaler and frame timing:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt<=0, idx<=idx+1, wrapping DIGITS-1 -> 0.
  - Frame boundary is the edge where cnt==SCAN_DIV-1 and idx==DIGITS-1. On that edge: disp<=pending (value and dp), and frame_done<=1 for exactly one cycle.
  - Frame period is DIGITS*SCAN_DIV cycles.
- Load:
  - On any edge with load=1, pending<=value and pending dp<=dp_in.
  - Multiple loads within a frame: the last one wins.
  - Load on the frame-boundary edge: disp receives the previous pending; the new value is displayed one frame later.
- Outputs are registered and reflect (idx, cnt, disp) of the previous cycle, i.e. 1-cycle latency.
- Guard interval (cnt < GUARD): an=all-off, seg=7'h7F, dp=1.
- Active portion of the slot: only an[idx] is enabled.
  - seg = decode(disp nibble idx).
  - dp = ~disp_dp[idx].
- Decode table, seg hex, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked when i>0 and disp nibbles i..DIGITS-1 are all zero.
  - A blanked digit gets seg=7'h7F but its anode is still enabled.
  - dp is NOT blanked; dp_in still lights the point on a blanked digit.
  - Digit 0 is never blanked.
  - blank_lz=0: all digits display normally.
- No combinational path from any input to any output.

Test Plan:
- Use DIGITS=4, SCAN_DIV=4, GUARD=1 for all scenarios.
- Reset mid-slot (idx=2, cnt=3) -> same-cycle seg=7F, an=F, dp=1, frame_done=0. After release, the first active slot is digit 0 and frame_done first pulses 16 cycles later.
- load value=16'h12AF, dp_in=0, blank_lz=0 -> next full frame shows:
  - digit0 seg=0E, digit1=08, digit2=24, digit3=79
  - each digit with an=only its bit low for 3 cycles after 1 guard cycle.
- Tearing check: load 16'h1111 mid-frame, then 16'h2222 before the boundary -> the current frame keeps the old value, and the next frame shows only 24 on all digits, never a mix.
- blank_lz=1, value=16'h0050 -> digit3 and digit2 seg=7F with anode enabled, digit1=12, digit0=40. With value=16'h0000, only digit0 shows 40.
- dp_in=4'b0100 with value=16'h0000, blank_lz=1 -> dp=0 only during digit2's active cycles; digit2 seg=7F.
- Free run over 64 cycles -> frame_done high exactly 4 times, each one cycle wide, 16 cycles apart. an is all-off on every guard cycle.
